// File: rtl/mux_2to1.sv
// Two-input N-bit word mux with a registered copy and a saturating select-switch counter.
// Define MUX21_PARITY_EN to add the registered even-parity output y_par.
module mux_2to1 #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             s,
  output logic [N-1:0]     y,
  output logic [N-1:0]     y_q,
  output logic             s_q,
`ifdef MUX21_PARITY_EN
  output logic             y_par,
`endif
  output logic [CNT_W-1:0] sw_cnt
);

  logic             s_prev_q;
  logic [CNT_W-1:0] sw_cnt_d;
  logic [CNT_W-1:0] sw_cnt_q;

  assign y = s ? b : a;

  // Count sampled select changes, holding at all-ones instead of wrapping.
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if ((s != s_prev_q) && !(&sw_cnt_q)) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      y_q      <= y;
      s_q      <= s;
      s_prev_q <= s;
      sw_cnt_q <= sw_cnt_d;
    end
  end

`ifdef MUX21_PARITY_EN
  logic y_par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_par_q <= 1'b0;
    end else begin
      y_par_q <= ^y;
    end
  end

  assign y_par = y_par_q;
`endif

  assign sw_cnt = sw_cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: table-driven combinational and registered vectors,
// plus hand-written reset and saturation sequences (second instance built with CNT_W=2).
module tb_mux_2to1;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        s;
  logic [31:0] y;
  logic [31:0] y_q;
  logic        s_q;
  logic [15:0] sw_cnt;

  logic        s_sat;
  logic [31:0] y_sat;
  logic [31:0] y_q_sat;
  logic        s_q_sat;
  logic [1:0]  sw_cnt_sat;
`ifdef MUX21_PARITY_EN
  logic        y_par;
  logic        y_par_sat;
`endif

  int unsigned errors;
  int unsigned checks;

  mux_2to1 #(
    .N     (32),
    .CNT_W (16)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .s      (s),
    .y      (y),
    .y_q    (y_q),
    .s_q    (s_q),
`ifdef MUX21_PARITY_EN
    .y_par  (y_par),
`endif
    .sw_cnt (sw_cnt)
  );

  mux_2to1 #(
    .N     (32),
    .CNT_W (2)
  ) u_dut_sat (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .s      (s_sat),
    .y      (y_sat),
    .y_q    (y_q_sat),
    .s_q    (s_q_sat),
`ifdef MUX21_PARITY_EN
    .y_par  (y_par_sat),
`endif
    .sw_cnt (sw_cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_y;
  } comb_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_yq;
    logic        exp_sq;
    logic [15:0] exp_cnt;
    logic        exp_par;
  } seq_vec_t;

  comb_vec_t cv[5];
  seq_vec_t  sv[7];
  logic [1:0] sat_exp[6];

  initial begin
    errors = 0;
    checks = 0;

    cv[0] = '{32'habcdef12, 32'h12345678, 1'b0, 32'habcdef12};
    cv[1] = '{32'habcdef12, 32'h12345678, 1'b1, 32'h12345678};
    cv[2] = '{32'habcdef12, 32'h12345678, 1'b0, 32'habcdef12};
    cv[3] = '{32'h00000000, 32'hffffffff, 1'b1, 32'hffffffff};
    cv[4] = '{32'h5a5a5a5a, 32'ha5a5a5a5, 1'b0, 32'h5a5a5a5a};

    // Parity: 12345678 has 13 ones, abcdef12 has 19, 00000001 has 1, 00000003 has 2.
    sv[0] = '{32'habcdef12, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 16'd1, 1'b1};
    sv[1] = '{32'habcdef12, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 16'd1, 1'b1};
    sv[2] = '{32'habcdef12, 32'h12345678, 1'b0, 32'habcdef12, 1'b0, 16'd2, 1'b1};
    sv[3] = '{32'habcdef12, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 16'd3, 1'b1};
    sv[4] = '{32'habcdef12, 32'h12345678, 1'b0, 32'habcdef12, 1'b0, 16'd4, 1'b1};
    sv[5] = '{32'h00000001, 32'h12345678, 1'b0, 32'h00000001, 1'b0, 16'd4, 1'b1};
    sv[6] = '{32'h00000001, 32'h00000003, 1'b1, 32'h00000003, 1'b1, 16'd5, 1'b0};

    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;
    sat_exp[5] = 2'd3;

    rst   = 1'b1;
    s     = 1'b0;
    s_sat = 1'b0;
    a     = '0;
    b     = '0;

    // Combinational select with no dependence on the clock.
    for (int i = 0; i < 5; i++) begin
      a = cv[i].a;
      b = cv[i].b;
      s = cv[i].s;
      #1;
      check($sformatf("comb_y[%0d]", i), y, cv[i].exp_y);
    end

    // Reset held for two edges with s=1.
    @(negedge clk);
    a = 32'habcdef12;
    b = 32'h12345678;
    s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_q", y_q, 32'h0);
    check("rst_s_q", 32'(s_q), 32'h0);
    check("rst_sw_cnt", 32'(sw_cnt), 32'h0);
    check("rst_y_comb", y, 32'h12345678);

    // Registered sequence; the first entry releases reset.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a = sv[i].a;
      b = sv[i].b;
      s = sv[i].s;
      if (i == 0) begin
        rst = 1'b0;
        #1;
        check("pre_edge_y_q", y_q, 32'h0);
        check("pre_edge_s_q", 32'(s_q), 32'h0);
      end
      @(posedge clk);
      #1;
      check($sformatf("seq_y_q[%0d]", i), y_q, sv[i].exp_yq);
      check($sformatf("seq_s_q[%0d]", i), 32'(s_q), 32'(sv[i].exp_sq));
      check($sformatf("seq_sw_cnt[%0d]", i), 32'(sw_cnt), 32'(sv[i].exp_cnt));
`ifdef MUX21_PARITY_EN
      check($sformatf("seq_y_par[%0d]", i), 32'(y_par), 32'(sv[i].exp_par));
`endif
    end

    // Mid-stream reset discards the in-flight value while inputs change.
    @(negedge clk);
    rst = 1'b1;
    a   = 32'hdeadbeef;
    s   = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_y_q", y_q, 32'h0);
    check("mid_rst_s_q", 32'(s_q), 32'h0);
    check("mid_rst_sw_cnt", 32'(sw_cnt), 32'h0);
    check("mid_rst_y_comb", y, 32'hdeadbeef);
`ifdef MUX21_PARITY_EN
    check("mid_rst_y_par", 32'(y_par), 32'h0);
`endif

    // s=0 straight after reset is not a transition.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_y_q", y_q, 32'hdeadbeef);
    check("post_rst_sw_cnt", 32'(sw_cnt), 32'h0);

    // Saturation on the CNT_W=2 instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_sat = (i % 2 == 0);
      @(posedge clk);
      #1;
      check($sformatf("sat_sw_cnt[%0d]", i), 32'(sw_cnt_sat), 32'(sat_exp[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
